// File: rtl/rob_core.sv
`default_nettype none
// ============================================================================
// Module   : rob_core
// Purpose  : Reorder buffer. Circular buffer of DEPTH entries that allocates
//            in program order, marks out-of-order completions, and retires
//            completed head entries in order. Flush empties the buffer.
//            Optional macro ROB_CMPL_BYPASS_EN lets a completion of the head
//            entry be offered for retire in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rob_core #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_valid,
    input  logic              alloc_has_dest,
    input  logic [4:0]        alloc_dr,
    input  logic [PREG_W-1:0] alloc_dr_p,
    input  logic [PREG_W-1:0] alloc_old_dr,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_rob_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_rob_idx,
    output logic              ret_valid,
    input  logic              ret_ready,
    output logic              ret_has_dest,
    output logic [4:0]        ret_dr,
    output logic [PREG_W-1:0] ret_dr_p,
    output logic [PREG_W-1:0] ret_old_dr,
    input  logic              flush,
    output logic [IDX_W:0]    count
);

    localparam logic [IDX_W:0]   c_DEPTH_CNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   c_CNT_ONE   = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    // Per-entry storage
    logic              valid_q    [DEPTH];
    logic              done_q     [DEPTH];
    logic              has_dest_q [DEPTH];
    logic [4:0]        dr_q       [DEPTH];
    logic [PREG_W-1:0] dr_p_q     [DEPTH];
    logic [PREG_W-1:0] old_dr_q   [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;

    logic              w_alloc_fire;
    logic              w_cmpl_fire;
    logic              w_ret_fire;
    logic              w_bypass;

`ifdef ROB_CMPL_BYPASS_EN
    assign w_bypass = cmpl_valid && (cmpl_rob_idx == head_q)
                      && valid_q[head_q] && !done_q[head_q];
`else
    assign w_bypass = 1'b0;
`endif

    // Full and empty both have head==tail; only the count tells them apart.
    assign alloc_ready   = (count_q < c_DEPTH_CNT) && !flush;
    assign alloc_rob_idx = tail_q;
    assign count         = count_q;

    assign ret_valid     = valid_q[head_q] && (done_q[head_q] || w_bypass) && !flush;
    assign ret_has_dest  = has_dest_q[head_q];
    assign ret_dr        = dr_q[head_q];
    assign ret_dr_p      = dr_p_q[head_q];
    assign ret_old_dr    = old_dr_q[head_q];

    always_comb begin
        w_alloc_fire = alloc_valid && alloc_ready;
        w_ret_fire   = ret_valid && ret_ready;
        w_cmpl_fire  = cmpl_valid && valid_q[cmpl_rob_idx] && !done_q[cmpl_rob_idx];
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_alloc_fire) begin
                tail_d = tail_q + c_IDX_ONE;
            end
            if (w_ret_fire) begin
                head_d = head_q + c_IDX_ONE;
            end
            case ({w_alloc_fire, w_ret_fire})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Alloc only targets an empty slot and retire only a full one, so the
    // three updates below never collide on the same entry in a useful way;
    // retire is ordered last so a head completed and retired together clears.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                done_q[i]     <= 1'b0;
                has_dest_q[i] <= 1'b0;
                dr_q[i]       <= '0;
                dr_p_q[i]     <= '0;
                old_dr_q[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
            end
        end else begin
            if (w_alloc_fire) begin
                valid_q[tail_q]    <= 1'b1;
                done_q[tail_q]     <= 1'b0;
                has_dest_q[tail_q] <= alloc_has_dest;
                dr_q[tail_q]       <= alloc_dr;
                dr_p_q[tail_q]     <= alloc_dr_p;
                old_dr_q[tail_q]   <= alloc_old_dr;
            end
            if (w_cmpl_fire) begin
                done_q[cmpl_rob_idx] <= 1'b1;
            end
            if (w_ret_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rob_core.md
ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, 4 to 64.
REQ-002 Parameter PREG_W, default 6, physical register tag width.
REQ-003 Parameter IDX_W, default 4, ROB index width, equal to log2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 alloc_valid  input  1  rename stage presents an instruction.
REQ-007 alloc_has_dest  input  1  instruction writes a register (not a store/branch/nop).
REQ-008 alloc_dr  input  5  architectural destination.
REQ-009 alloc_dr_p  input  PREG_W  new physical destination from rename.
REQ-010 alloc_old_dr  input  PREG_W  previous mapping of alloc_dr, freed at retire.
REQ-011 alloc_ready  output  1  ROB can accept an allocation this cycle.
REQ-012 alloc_rob_idx  output  IDX_W  index assigned to the current allocation (tail pointer).
REQ-013 cmpl_valid  input  1  execute reports completion.
REQ-014 cmpl_rob_idx  input  IDX_W  index of the completing entry.
REQ-015 ret_valid  output  1  head entry is complete and is offered for retire.
REQ-016 ret_ready  input  1  free-list/commit side accepts the retire.
REQ-017 ret_has_dest, ret_dr, ret_dr_p, ret_old_dr  output  1/5/PREG_W/PREG_W  fields of the head entry.
REQ-018 flush  input  1  discard all entries (mispredict/exception).
REQ-019 count  output  IDX_W+1  number of occupied entries.

Function
REQ-020 Entries are a circular buffer; head and tail pointers wrap modulo DEPTH.
REQ-021 Each entry holds valid, done, has_dest, dr, dr_p and old_dr.
REQ-022 alloc_ready shall be 1 iff registered count < DEPTH; same-cycle retire does not raise it.
REQ-023 Allocation fires when alloc_valid && alloc_ready; the entry at tail is written with valid=1 and done=0, and tail advances by 1.
REQ-024 alloc_rob_idx shall equal tail combinationally, valid in the allocation cycle.
REQ-025 Completion: cmpl_valid sets done=1 on cmpl_rob_idx at the next edge, only if that entry is valid.
REQ-026 Completion on an invalid entry or an already-done entry shall have no effect.
REQ-027 ret_valid shall be 1 when the head entry is valid && done && !flush; ret_* fields always reflect the head entry.
REQ-028 Retire fires when ret_valid && ret_ready: the head entry is cleared to valid=0 and head advances by 1.
REQ-029 Retire occurs at most once per cycle, strictly in program order.
REQ-030 ret_* fields shall hold stable while ret_valid=1 and ret_ready=0.
REQ-031 count shall be incremented by allocation, decremented by retire, and unchanged when both fire in the same cycle.
REQ-032 flush has priority over alloc, cmpl and retire: next cycle all valid=0, head=tail=0, count=0.
REQ-033 During the flush cycle, alloc_ready=0 and ret_valid=0.
REQ-034 When full (count=DEPTH), head==tail; full and empty shall be distinguished by count only.

Reset
REQ-035 While rstn=0, all entries have valid=0 and done=0, with head=0, tail=0 and count=0.
REQ-036 Outputs during reset: alloc_ready=1, alloc_rob_idx=0, ret_valid=0, ret_* fields=0.
REQ-037 A reset asserted mid-operation discards all entries immediately, with no retire issued.

Configuration
REQ-038 Macro ROB_CMPL_BYPASS_EN selects completion-to-retire timing at the head.
REQ-039 With the macro defined, cmpl_valid targeting the valid, not-done head entry makes ret_valid=1 in the same cycle (combinational bypass); if retired, the entry clears normally.
REQ-040 Without the macro, the earliest retire of a completed entry is the cycle after completion.

Verification
REQ-041 Reset, then 16 allocations with no completions -> alloc_rob_idx 0..15, count=16, alloc_ready=0 on the 17th attempt, tail=0.
REQ-042 Allocate 3 entries (dr_p 33, 34, 35), then complete idx 2, then 0 -> ret_valid only after idx 0 is done; retire order 33 then stall until idx 1 completes.
REQ-043 Full ROB with head done, ret_ready=1 and alloc_valid=1 in the same cycle -> retire fires, alloc refused, count=15 next cycle.
REQ-044 Entries 5..9 valid, assert flush together with alloc and cmpl -> next cycle count=0, alloc_rob_idx=0, ret_valid=0.
REQ-045 ret_ready held 0 for 3 cycles with the head done (old_dr=7) -> ret_old_dr=7 stable and ret_valid=1 throughout; retired on the first ret_ready=1.
REQ-046 Complete the head at cycle N -> ret_valid at N with ROB_CMPL_BYPASS_EN defined, at N+1 without it.
